// File: rtl/trace_dispatcher_if.sv
// Trace dispatcher bus bundle: command input plus data-cache and
// instruction-cache output channels. The dispatcher uses the slave view,
// a command source / cache model uses the master view.
interface trace_dispatcher_if #(
  parameter int unsigned ADDR_W = 32
);
  // Trace command input channel
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_cmd;
  logic [ADDR_W-1:0] in_addr;
  logic              in_last;

  // Data-cache channel
  logic              d_valid;
  logic              d_ready;
  logic [3:0]        d_cmd;
  logic [ADDR_W-1:0] d_addr;

  // Instruction-cache channel
  logic              i_valid;
  logic              i_ready;
  logic [3:0]        i_cmd;
  logic [ADDR_W-1:0] i_addr;

  modport slave (
    input  in_valid, in_cmd, in_addr, in_last, d_ready, i_ready,
    output in_ready, d_valid, d_cmd, d_addr, i_valid, i_cmd, i_addr
  );

  modport master (
    output in_valid, in_cmd, in_addr, in_last, d_ready, i_ready,
    input  in_ready, d_valid, d_cmd, d_addr, i_valid, i_cmd, i_addr
  );
endinterface

// File: rtl/trace_dispatcher.sv
// Trace dispatcher: buffers trace commands in a FIFO and routes each head
// entry to the data-cache channel, the instruction-cache channel, or both.
// Invalid command codes are dropped and counted; an entry flagged last
// ends the trace and locks the block until reset.
// Optional per-class statistics counters: define TRACE_DISPATCH_STATS_EN.
module trace_dispatcher #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  trace_dispatcher_if.slave   bus,
  output logic                done,
  output logic [CNT_W-1:0]    err_count
`ifdef TRACE_DISPATCH_STATS_EN
  ,
  output logic [CNT_W-1:0]    rd_count,
  output logic [CNT_W-1:0]    wr_count,
  output logic [CNT_W-1:0]    if_count,
  output logic [CNT_W-1:0]    snoop_count,
  output logic [CNT_W-1:0]    bcast_count
`endif
);

  localparam int unsigned   PTR_W     = $clog2(DEPTH);
  localparam logic [PTR_W:0] FIFO_FULL = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    FINISHED = 2'd2
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // FIFO storage (no reset needed: occupancy and pointers define validity)
  logic [3:0]        cmd_mem_q  [DEPTH];
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic              last_mem_q [DEPTH];

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              d_sent_q, d_sent_d;
  logic              i_sent_q, i_sent_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic              ready_en_q, ready_en_d;
`ifdef TRACE_DISPATCH_STATS_EN
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  if_cnt_q, if_cnt_d;
  logic [CNT_W-1:0]  snoop_cnt_q, snoop_cnt_d;
  logic [CNT_W-1:0]  bcast_cnt_q, bcast_cnt_d;
`endif

  logic [3:0]        head_cmd;
  logic [ADDR_W-1:0] head_addr;
  logic              head_last;
  logic              tgt_d, tgt_i, cmd_ok;
  logic              issuing, d_vld, i_vld, in_rdy;
  logic              push, pop, d_hs, i_hs, d_clr, i_clr;

  // Decode the FIFO head into its target channel(s)
  always_comb begin
    head_cmd  = cmd_mem_q[rd_ptr_q];
    head_addr = addr_mem_q[rd_ptr_q];
    head_last = last_mem_q[rd_ptr_q];
    tgt_d     = 1'b0;
    tgt_i     = 1'b0;
    case (head_cmd)
      4'd0, 4'd1, 4'd3, 4'd4: tgt_d = 1'b1;
      4'd2:                   tgt_i = 1'b1;
      4'd8, 4'd9: begin
        tgt_d = 1'b1;
        tgt_i = 1'b1;
      end
      default: ;
    endcase
    cmd_ok = tgt_d | tgt_i;
  end

  // Handshake outputs derived only from registered state (never from x_ready);
  // rst_n gating forces them low for the whole time reset is asserted
  always_comb begin
    issuing = rst_n && (state_q == ISSUE);
    d_vld   = issuing && tgt_d && !d_sent_q;
    i_vld   = issuing && tgt_i && !i_sent_q;
    in_rdy  = rst_n && ready_en_q && !done_q && (count_q != FIFO_FULL);
  end

  assign bus.in_ready = in_rdy;
  assign bus.d_valid  = d_vld;
  assign bus.d_cmd    = d_vld ? head_cmd  : '0;
  assign bus.d_addr   = d_vld ? head_addr : '0;
  assign bus.i_valid  = i_vld;
  assign bus.i_cmd    = i_vld ? head_cmd  : '0;
  assign bus.i_addr   = i_vld ? head_addr : '0;
  assign done         = done_q;
  assign err_count    = err_cnt_q;
`ifdef TRACE_DISPATCH_STATS_EN
  assign rd_count     = rd_cnt_q;
  assign wr_count     = wr_cnt_q;
  assign if_count     = if_cnt_q;
  assign snoop_count  = snoop_cnt_q;
  assign bcast_count  = bcast_cnt_q;
`endif

  // Next-state: FIFO bookkeeping, per-channel completion and FSM transitions
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    d_sent_d   = d_sent_q;
    i_sent_d   = i_sent_q;
    done_d     = done_q;
    err_cnt_d  = err_cnt_q;
    ready_en_d = 1'b1;
`ifdef TRACE_DISPATCH_STATS_EN
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    if_cnt_d    = if_cnt_q;
    snoop_cnt_d = snoop_cnt_q;
    bcast_cnt_d = bcast_cnt_q;
`endif

    push  = bus.in_valid && in_rdy;
    d_hs  = d_vld && bus.d_ready;
    i_hs  = i_vld && bus.i_ready;
    // A channel is finished when untargeted, already sent, or sending now;
    // an invalid code targets nothing and therefore pops immediately
    d_clr = !tgt_d || d_sent_q || d_hs;
    i_clr = !tgt_i || i_sent_q || i_hs;
    pop   = (state_q == ISSUE) && d_clr && i_clr;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase

    if (pop) begin
      d_sent_d = 1'b0;
      i_sent_d = 1'b0;
    end else begin
      d_sent_d = d_sent_q | d_hs;
      i_sent_d = i_sent_q | i_hs;
    end

    case (state_q)
      IDLE: begin
        if (count_q != '0) state_d = ISSUE;
      end
      ISSUE: begin
        if (pop) begin
          if (!cmd_ok) err_cnt_d = sat_inc(err_cnt_q);
          if (head_last) begin
            // End of trace: anything still queued (or pushed now) is discarded
            state_d  = FINISHED;
            done_d   = 1'b1;
            count_d  = '0;
            rd_ptr_d = wr_ptr_d;
          end else if (count_d == '0) begin
            state_d = IDLE;
          end
        end
      end
      FINISHED: ;
      default: state_d = IDLE;
    endcase

`ifdef TRACE_DISPATCH_STATS_EN
    if (pop) begin
      case (head_cmd)
        4'd0:       rd_cnt_d    = sat_inc(rd_cnt_q);
        4'd1:       wr_cnt_d    = sat_inc(wr_cnt_q);
        4'd2:       if_cnt_d    = sat_inc(if_cnt_q);
        4'd3, 4'd4: snoop_cnt_d = sat_inc(snoop_cnt_q);
        4'd8, 4'd9: bcast_cnt_d = sat_inc(bcast_cnt_q);
        default: ;
      endcase
    end
`endif
  end

  // Control and status registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      d_sent_q   <= 1'b0;
      i_sent_q   <= 1'b0;
      done_q     <= 1'b0;
      err_cnt_q  <= '0;
      ready_en_q <= 1'b0;
`ifdef TRACE_DISPATCH_STATS_EN
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      if_cnt_q    <= '0;
      snoop_cnt_q <= '0;
      bcast_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      d_sent_q   <= d_sent_d;
      i_sent_q   <= i_sent_d;
      done_q     <= done_d;
      err_cnt_q  <= err_cnt_d;
      ready_en_q <= ready_en_d;
`ifdef TRACE_DISPATCH_STATS_EN
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      if_cnt_q    <= if_cnt_d;
      snoop_cnt_q <= snoop_cnt_d;
      bcast_cnt_q <= bcast_cnt_d;
`endif
    end
  end

  // FIFO write port
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      cmd_mem_q[wr_ptr_q]  <= bus.in_cmd;
      addr_mem_q[wr_ptr_q] <= bus.in_addr;
      last_mem_q[wr_ptr_q] <= bus.in_last;
    end
  end

endmodule

// File: doc/trace_dispatcher.md
TRACE_DISPATCHER -- requirements
Module: trace_dispatcher

Interface
REQ-001 Parameter ADDR_W, default 32, trace address width.
REQ-002 Parameter DEPTH, default 8, command FIFO entries; power of two, >=2.
REQ-003 Parameter CNT_W, default 16, statistics counter width.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 in_valid/in_ready  input/output  1/1  trace command handshake; transfer when both high.
REQ-007 in_cmd  input  4  trace number; in_addr  input  ADDR_W  trace address; in_last  input  1  marks final trace line.
REQ-008 d_valid/d_ready  output/input  1/1  data-cache channel handshake; d_cmd  output  4; d_addr  output  ADDR_W.
REQ-009 i_valid/i_ready  output/input  1/1  instruction-cache channel handshake; i_cmd  output  4; i_addr  output  ADDR_W.
REQ-010 done  output  1  sticky end-of-trace flag; err_count  output  CNT_W  dropped-command count.

Function
REQ-011 FIFO SHALL store {cmd, addr, last}; in_ready SHALL equal !full && !done && reset high; full when occupancy == DEPTH.
REQ-012 Push at edge k SHALL make the entry visible at the FIFO head after edge k; no same-cycle bypass.
REQ-013 FSM states SHALL be IDLE (FIFO empty), ISSUE (head presented), FINISHED (done set).
REQ-014 IDLE->ISSUE at the first edge with FIFO non-empty; minimum input-to-output latency 2 cycles.
REQ-015 Routing: cmd 0,1,3,4 -> data channel only; cmd 2 -> instruction channel only; cmd 8,9 -> both channels (broadcast); all other codes invalid.
REQ-016 In ISSUE, x_valid SHALL be high for each targeted channel whose sent flag is clear; x_cmd/x_addr SHALL equal the head and stay stable while x_valid is high.
REQ-017 A channel's sent flag SHALL set on x_valid && x_ready; x_valid for that channel SHALL drop the following cycle.
REQ-018 Head SHALL pop at the edge where the last outstanding targeted channel handshakes; sent flags clear at that edge.
REQ-019 Broadcast channels SHALL complete independently, in either order or the same cycle.
REQ-020 Invalid cmd SHALL be popped in its first ISSUE cycle with no valid asserted, and err_count SHALL increment, saturating at all-ones.
REQ-021 After a pop, ISSUE->ISSUE if FIFO non-empty (one single-target command per cycle sustained), else ISSUE->IDLE.
REQ-022 Push and pop in the same cycle SHALL leave occupancy unchanged; pointers wrap modulo DEPTH.
REQ-023 Popping an entry with last=1 SHALL set done at that edge and enter FINISHED; FINISHED holds until reset, ignores in_valid, and any entries remaining in the FIFO are discarded.
REQ-024 Output valids SHALL never depend combinationally on x_ready.

Reset
REQ-025 With reset low at an edge: FIFO emptied, state IDLE, sent flags cleared, done=0, err_count=0, all counters 0.
REQ-026 During reset and the following cycle, in_ready, d_valid and i_valid SHALL be 0; d_cmd/i_cmd/d_addr/i_addr SHALL be 0.
REQ-027 Reset mid-handshake SHALL abandon the in-flight command; it SHALL not be reissued.

Configuration
REQ-028 Macro TRACE_DISPATCH_STATS_EN, when defined, SHALL add outputs rd_count, wr_count, if_count, snoop_count (cmd 3,4), bcast_count (cmd 8,9), each CNT_W, saturating, incremented on pop of a matching command.
REQ-029 Without TRACE_DISPATCH_STATS_EN these ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-030 Push cmd 0 addr 0x0000_1000, d_ready=1 -> d_valid for exactly one cycle with d_addr=0x0000_1000, 2 cycles after push; i_valid stays 0.
REQ-031 Push cmd 9 with d_ready=1, i_ready=0 for 3 cycles -> d handshake once, i_valid held 3 cycles with stable i_addr, pop only after i handshake; bcast_count=1 if stats enabled.
REQ-032 d_ready=0, push 8 cmd-0 entries -> in_ready=0 after 8th; 9th in_valid not accepted; release d_ready -> 8 commands delivered in order on consecutive cycles.
REQ-033 Push cmd 5, then cmd 2 addr 0x40 -> no output for cmd 5, err_count=1; i_valid with i_addr=0x40.
REQ-034 Push cmd 1 with in_last=1, then cmd 0 -> done=1 after cmd 1 handshake, in_ready=0, cmd 0 never issued.
REQ-035 Assert reset low while d_valid=1 and FIFO holds 3 entries -> next cycle d_valid=0, in_ready=0, done=0; after release, FIFO empty and no stale command issued.
